alu_instr_sequencer: RTL and testbench

Front-end stage that feeds the register-file/ALU datapath. Accepts 32-bit RISC-V R-type instructions over a valid/ready handshake and buffers them in a 4-entry FIFO. Decodes each instruction into the datapath's read/write register addresses and 4-bit ALU control, then sequences the read → execute → write-back cycles, pulsing the register-file write enable once per instruction. Also keeps retired and illegal-instruction counters.

---
 rtl/alu_instr_sequencer.sv | 163 ++++++++++++++++
 tb/tb_alu_instr_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_instr_sequencer.sv
// alu_instr_sequencer: R-type instruction FIFO, decoder and
// read/execute/write-back sequencer for the register-file/ALU datapath.
module alu_instr_sequencer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [31:0]      in_instr,
    output logic             in_ready,
    output logic [4:0]       rr1,
    output logic [4:0]       rr2,
    output logic [4:0]       wr,
    output logic [3:0]       ctl,
    output logic             rw,
    input  logic             zero,
    output logic             last_zero,
    output logic             busy,
    output logic [CNT_W-1:0] retired,
    output logic [CNT_W-1:0] illegal
);

    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        EX,
        WB
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       mem_q [DEPTH];
    logic [PW:0]       wp_q, rp_q;
    logic [4:0]        rr1_q, rr1_d;
    logic [4:0]        rr2_q, rr2_d;
    logic [4:0]        wr_q, wr_d;
    logic [3:0]        ctl_q, ctl_d;
    logic              rw_q, rw_d;
    logic              lz_q, lz_d;
    logic [CNT_W-1:0]  ret_q, ret_d;
    logic [CNT_W-1:0]  ill_q, ill_d;

    logic              full, empty, push, pop;
    logic [31:0]       head;
    logic              legal;
    logic [3:0]        hctl;

    // Full when pointers differ only in the wrap bit.
    assign full  = (wp_q[PW] != rp_q[PW]) &&
                   (wp_q[PW-1:0] == rp_q[PW-1:0]);
    assign empty = (wp_q == rp_q);
    assign push  = in_valid && !full;
    assign head  = mem_q[rp_q[PW-1:0]];

    // Decode the FIFO head into legality and ALU control.
    always_comb begin
        legal = 1'b0;
        hctl  = 4'b0000;
        if (head[6:0] == 7'b0110011) begin
            case ({head[31:25], head[14:12]})
                10'b0000000_000: begin legal = 1'b1; hctl = 4'b0010; end
                10'b0100000_000: begin legal = 1'b1; hctl = 4'b0110; end
                10'b0000000_111: begin legal = 1'b1; hctl = 4'b0000; end
                10'b0000000_110: begin legal = 1'b1; hctl = 4'b0001; end
                10'b0000000_010: begin legal = 1'b1; hctl = 4'b0111; end
                default:         begin legal = 1'b0; hctl = 4'b0000; end
            endcase
        end
    end

    // Next-state, pop and register updates for the sequencer.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        rr1_d   = rr1_q;
        rr2_d   = rr2_q;
        wr_d    = wr_q;
        ctl_d   = ctl_q;
        lz_d    = lz_q;
        ret_d   = ret_q;
        ill_d   = ill_q;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (legal) begin
                        state_d = RD;
                    end else if (ill_q != {CNT_W{1'b1}}) begin
                        ill_d = ill_q + 1'b1;
                    end
                end
            end
            RD: state_d = EX;
            EX: state_d = WB;
            WB: begin
                lz_d  = zero;
                ret_d = ret_q + 1'b1;
                if (!empty && legal) begin
                    pop     = 1'b1;
                    state_d = RD;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (pop && legal) begin
            rr1_d = head[19:15];
            rr2_d = head[24:20];
            wr_d  = head[11:7];
            ctl_d = hctl;
        end
        rw_d = (state_d == WB) && (wr_q != 5'd0);
    end

    // FIFO storage; contents need no reset, the pointers gate them.
    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q[PW-1:0]] <= in_instr;
    end

    // Pointers, FSM state and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            wp_q    <= '0;
            rp_q    <= '0;
            rr1_q   <= '0;
            rr2_q   <= '0;
            wr_q    <= '0;
            ctl_q   <= '0;
            rw_q    <= 1'b0;
            lz_q    <= 1'b0;
            ret_q   <= '0;
            ill_q   <= '0;
        end else begin
            state_q <= state_d;
            if (push) wp_q <= wp_q + 1'b1;
            if (pop)  rp_q <= rp_q + 1'b1;
            rr1_q   <= rr1_d;
            rr2_q   <= rr2_d;
            wr_q    <= wr_d;
            ctl_q   <= ctl_d;
            rw_q    <= rw_d;
            lz_q    <= lz_d;
            ret_q   <= ret_d;
            ill_q   <= ill_d;
        end
    end

    assign in_ready  = !full;
    assign rr1       = rr1_q;
    assign rr2       = rr2_q;
    assign wr        = wr_q;
    assign ctl       = ctl_q;
    assign rw        = rw_q;
    assign last_zero = lz_q;
    assign busy      = (state_q != IDLE) || !empty;
    assign retired   = ret_q;
    assign illegal   = ill_q;

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// tb_alu_instr_sequencer: scoreboard bench for the instruction
// sequencer; expected decodes queue on push, pop on each rw pulse.
module tb_alu_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic        in_ready;
    logic [4:0]  rr1, rr2, wr;
    logic [3:0]  ctl;
    logic        rw;
    logic        zero = 1'b0;
    logic        last_zero;
    logic        busy;
    logic [7:0]  retired, illegal;

    alu_instr_sequencer #(.DEPTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
        .rr1(rr1), .rr2(rr2), .wr(wr), .ctl(ctl), .rw(rw),
        .zero(zero), .last_zero(last_zero), .busy(busy),
        .retired(retired), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] r1;
        logic [4:0] r2;
        logic [4:0] w;
        logic [3:0] c;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_err = 0;
    int   exp_ret = 0;
    int   exp_ill = 0;
    int   cyc = 0;
    int   p_cyc = 0;
    int   last_rw = -1;
    bit   lat_on = 0;
    bit   spc_on = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] expv);
        n_chk++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [6:0] f7,
        input logic [4:0] rs2, input logic [4:0] rs1,
        input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    // Reference decode straight from the opcode/funct table.
    function automatic void model(input logic [31:0] ins);
        logic       ok;
        logic [3:0] c;
        exp_t       e;
        ok = 1'b1;
        c  = 4'b0000;
        if (ins[6:0] != 7'b0110011) ok = 1'b0;
        else case ({ins[31:25], ins[14:12]})
            10'b0000000000: c = 4'b0010;
            10'b0100000000: c = 4'b0110;
            10'b0000000111: c = 4'b0000;
            10'b0000000110: c = 4'b0001;
            10'b0000000010: c = 4'b0111;
            default: ok = 1'b0;
        endcase
        if (ok) begin
            exp_ret++;
            if (ins[11:7] != 5'd0) begin
                e.r1 = ins[19:15];
                e.r2 = ins[24:20];
                e.w  = ins[11:7];
                e.c  = c;
                q.push_back(e);
            end
        end else if (exp_ill != 255) begin
            exp_ill++;
        end
    endfunction

    // Every write-back pulse must match the oldest outstanding entry.
    always @(negedge clk) begin
        if (rst && rw) begin
            if (q.size() == 0) begin
                chk("rw_unexpected", 1, 0);
            end else begin
                mon_e = q.pop_front();
                chk("rr1", rr1, mon_e.r1);
                chk("rr2", rr2, mon_e.r2);
                chk("wr", wr, mon_e.w);
                chk("ctl", ctl, mon_e.c);
            end
            if (lat_on) chk("latency", cyc - p_cyc, 3);
            lat_on = 0;
            if (spc_on) begin
                if (last_rw >= 0) chk("rw_gap", cyc - last_rw, 3);
                last_rw = cyc;
            end
        end
    end

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic push(input logic [31:0] ins, input bit rdy_chk);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_instr = ins;
        if (rdy_chk) chk("in_ready_b2b", in_ready, 1);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("push_timeout", 1, 0);
        @(posedge clk);
        #1 p_cyc = cyc;
        model(ins);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) chk({tag, "_idle_timeout"}, 1, 0);
        chk({tag, "_retired"}, retired, exp_ret);
        chk({tag, "_illegal"}, illegal, exp_ill);
        chk({tag, "_pending"}, q.size(), 0);
    endtask

    function automatic logic [31:0] mk(input int k);
        logic [4:0] rd, rs1, rs2;
        rd  = 5'(k + 10);
        rs1 = 5'(k + 1);
        rs2 = 5'(k + 20);
        case (k % 5)
            0: return rtype(7'h00, rs2, rs1, 3'd0, rd);
            1: return rtype(7'h20, rs2, rs1, 3'd0, rd);
            2: return rtype(7'h00, rs2, rs1, 3'd7, rd);
            3: return rtype(7'h00, rs2, rs1, 3'd6, rd);
            default: return rtype(7'h00, rs2, rs1, 3'd2, rd);
        endcase
    endfunction

    initial begin
        int  acc;
        bit  saw_full;
        logic [31:0] bad;

        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rw", rw, 0);
        chk("rst_wr", wr, 0);
        chk("rst_ctl", ctl, 0);
        chk("rst_retired", retired, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_last_zero", last_zero, 0);
        rst = 1'b1;
        @(negedge clk);

        lat_on = 1;
        push(32'h002081B3, 1'b0);
        wait_idle("single_add");
        chk("latency_seen", lat_on, 0);

        spc_on  = 1;
        last_rw = -1;
        push(rtype(7'h20, 5'd6, 5'd5, 3'd0, 5'd4), 1'b1);
        push(rtype(7'h00, 5'd9, 5'd8, 3'd7, 5'd7), 1'b1);
        push(rtype(7'h00, 5'd12, 5'd11, 3'd6, 5'd10), 1'b1);
        push(rtype(7'h00, 5'd15, 5'd14, 3'd2, 5'd13), 1'b1);
        wait_idle("b2b");
        spc_on = 0;

        acc      = 0;
        saw_full = 0;
        for (int c = 0; c < 7; c++) begin
            in_valid = 1'b1;
            in_instr = mk(acc);
            if (in_ready) begin
                @(posedge clk);
                model(in_instr);
                acc++;
            end else begin
                saw_full = 1;
                @(posedge clk);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("hold_accepted", acc, 6);
        chk("hold_saw_full", saw_full, 1);
        wait_idle("hold");

        push(32'h00000013, 1'b0);
        push(rtype(7'h00, 5'd5, 5'd4, 3'd0, 5'd7), 1'b0);
        wait_idle("illegal_then_add");

        zero = 1'b1;
        push(rtype(7'h00, 5'd2, 5'd1, 3'd0, 5'd0), 1'b0);
        wait_idle("x0_write");
        chk("x0_last_zero", last_zero, 1);
        zero = 1'b0;

        push(rtype(7'h00, 5'd2, 5'd1, 3'd0, 5'd5), 1'b0);
        push(rtype(7'h00, 5'd3, 5'd1, 3'd0, 5'd6), 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        q.delete();
        exp_ret = 0;
        exp_ill = 0;
        chk("mid_rst_rw", rw, 0);
        chk("mid_rst_rr1", rr1, 0);
        chk("mid_rst_wr", wr, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_retired", retired, 0);
        chk("mid_rst_illegal", illegal, 0);
        chk("mid_rst_last_zero", last_zero, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_retired", retired, 0);

        for (int i = 0; i < 260; i++) begin
            case (i % 3)
                0: bad = 32'h00000013;
                1: bad = rtype(7'h00, 5'd2, 5'd1, 3'd4, 5'd3);
                default: bad = rtype(7'h01, 5'd2, 5'd1, 3'd0, 5'd3);
            endcase
            push(bad, 1'b0);
        end
        wait_idle("illegal_sat");
        chk("illegal_sat_val", illegal, 8'hFF);

        push(32'h002081B3, 1'b0);
        wait_idle("after_sat");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
